cvp_mem_responder: RTL and testbench

Memory-side responder for the CVP14 core's single-port memory bus. It holds a word-addressed data store that serves the core's instruction fetches, scalar and vector loads, and scalar and vector stores. It answers the core's RD and WR strobes with fixed-latency read data and single-cycle write commit. After reset it sweeps the store to zero before accepting requests.

---
 rtl/cvp_memresp_pkg.sv | 14 +
 rtl/cvp_memresp_rdpipe.sv | 49 ++++
 rtl/cvp_mem_responder.sv | 152 +++++++++++++++
 tb/tb_cvp_mem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cvp_memresp_pkg.sv
// Shared types and constants for the CVP14 memory responder.
package cvp_memresp_pkg;

    typedef enum logic {
        INIT   = 1'b0,
        ACTIVE = 1'b1
    } memState_t;

    localparam int DEFAULT_DEPTH    = 1024;
    localparam int DEFAULT_READ_LAT = 1;
    localparam int WORD_W           = 16;
    localparam logic [WORD_W-1:0] CLEAR_WORD = 16'h0000;

endpackage

// File: rtl/cvp_memresp_rdpipe.sv
// LAT-deep read-return pipeline carrying {data, valid, err}; FlushN is an async active-low flush.
module cvp_memresp_rdpipe
    import cvp_memresp_pkg::*;
#(
    parameter int LAT = DEFAULT_READ_LAT
) (
    input  logic              Clk1,
    input  logic              FlushN,
    input  logic [WORD_W-1:0] InData,
    input  logic              InValid,
    input  logic              InErr,
    output logic [WORD_W-1:0] OutData,
    output logic              OutValid,
    output logic              OutErr
);

    logic [WORD_W-1:0] data_r [LAT];
    logic [LAT-1:0]    valid_r;
    logic [LAT-1:0]    err_r;

    // Shift stages; data only advances with a valid beat so the output holds between reads.
    always_ff @(posedge Clk1 or negedge FlushN) begin
        if (!FlushN) begin
            for (int i = 0; i < LAT; i++) begin
                data_r[i] <= CLEAR_WORD;
            end
            valid_r <= '0;
            err_r   <= '0;
        end else begin
            valid_r[0] <= InValid;
            err_r[0]   <= InValid & InErr;
            if (InValid) begin
                data_r[0] <= InData;
            end
            for (int i = 1; i < LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
                err_r[i]   <= err_r[i-1];
                if (valid_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    assign OutData  = data_r[LAT-1];
    assign OutValid = valid_r[LAT-1];
    assign OutErr   = err_r[LAT-1];

endmodule

// File: rtl/cvp_mem_responder.sv
// Word-addressed store answering CVP14 RD/WR strobes, cleared to zero after reset.
// Optional macro CVP_MEMRESP_ERR_EN adds the Err port and out-of-range/illegal-request checking.
module cvp_mem_responder
    import cvp_memresp_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int READ_LAT = DEFAULT_READ_LAT
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] WrData,
    output logic [15:0] RdData,
    output logic        RdValid,
    output logic        Ready
`ifdef CVP_MEMRESP_ERR_EN
    ,
    output logic        Err
`endif
);

    localparam int AW = $clog2(DEPTH);

    memState_t         state_r;
    logic [AW-1:0]     clearCnt_r;
    logic              ready_r;
    logic [WORD_W-1:0] mem_r [DEPTH];

    logic [AW-1:0]     idx_s;
    logic              oor_s;
    logic              rdReq_s;
    logic              wrReq_s;
    logic              bothReq_s;
    logic              memWe_s;
    logic [AW-1:0]     memWAddr_s;
    logic [WORD_W-1:0] memWData_s;
    logic [WORD_W-1:0] rdData_s;
    logic [WORD_W-1:0] pipeData_s;
    logic              pipeValid_s;
    logic              pipeErr_s;

    assign idx_s = Addr[AW-1:0];

`ifdef CVP_MEMRESP_ERR_EN
    logic errWr_r;
    assign oor_s = ({1'b0, Addr} >= 17'(DEPTH));
`else
    logic unusedBits_s;
    assign oor_s        = 1'b0;
    assign unusedBits_s = ^{Addr, pipeErr_s};
`endif

    // Requests count only once the clear sweep and the transition cycle are done.
    assign rdReq_s   = ready_r & RD & ~WR;
    assign wrReq_s   = ready_r & WR & ~RD;
    assign bothReq_s = ready_r & RD & WR;

    // Store write port: clear sweep during INIT, core writes afterwards.
    always_comb begin
        memWe_s    = 1'b0;
        memWAddr_s = clearCnt_r;
        memWData_s = CLEAR_WORD;
        if (state_r == INIT) begin
            memWe_s    = 1'b1;
            memWAddr_s = clearCnt_r;
            memWData_s = CLEAR_WORD;
        end else if (wrReq_s && !oor_s) begin
            memWe_s    = 1'b1;
            memWAddr_s = idx_s;
            memWData_s = WrData;
        end else begin
            memWe_s    = 1'b0;
        end
    end

    // Read data selection; out-of-range reads return zero.
    always_comb begin
        rdData_s = CLEAR_WORD;
        if (oor_s) begin
            rdData_s = CLEAR_WORD;
        end else begin
            rdData_s = mem_r[idx_s];
        end
    end

    // Store array write.
    always_ff @(posedge Clk1) begin
        if (memWe_s) begin
            mem_r[memWAddr_s] <= memWData_s;
        end
    end

    // Clear/active state machine with registered Ready.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state_r    <= INIT;
            clearCnt_r <= '0;
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    clearCnt_r <= clearCnt_r + AW'(1);
                    ready_r    <= 1'b0;
                    if (clearCnt_r == AW'(DEPTH - 1)) begin
                        state_r <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= INIT;
                    clearCnt_r <= '0;
                    ready_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CVP_MEMRESP_ERR_EN
    // Write-side and illegal-request error pulse, one cycle after the offending edge.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            errWr_r <= 1'b0;
        end else begin
            errWr_r <= bothReq_s | (wrReq_s & oor_s);
        end
    end

    assign Err = pipeErr_s | errWr_r;
`endif

    cvp_memresp_rdpipe #(
        .LAT(READ_LAT)
    ) uRdPipe (
        .Clk1    (Clk1),
        .FlushN  (Reset),
        .InData  (rdData_s),
        .InValid (rdReq_s),
        .InErr   (oor_s),
        .OutData (pipeData_s),
        .OutValid(pipeValid_s),
        .OutErr  (pipeErr_s)
    );

    assign RdData  = pipeData_s;
    assign RdValid = pipeValid_s;
    assign Ready   = ready_r;

endmodule

// File: tb/tb_cvp_mem_responder.sv
// Directed self-checking bench for cvp_mem_responder (READ_LAT=1, DEPTH=1024).
module tb_cvp_mem_responder;

    localparam int DEPTH = 1024;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        RdValid;
    logic        Ready;
`ifdef CVP_MEMRESP_ERR_EN
    logic        Err;
`endif

    int checks = 0;
    int errors = 0;

    cvp_mem_responder #(
        .DEPTH   (DEPTH),
        .READ_LAT(1)
    ) dut (
        .Clk1   (Clk1),
        .Reset  (Reset),
        .Addr   (Addr),
        .RD     (RD),
        .WR     (WR),
        .WrData (WrData),
        .RdData (RdData),
        .RdValid(RdValid),
        .Ready  (Ready)
`ifdef CVP_MEMRESP_ERR_EN
        ,
        .Err    (Err)
`endif
    );

    always #5 Clk1 = ~Clk1;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk1);
        #1;
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
        Addr = a; WrData = d; WR = 1'b1; RD = 1'b0;
        step();
        WR = 1'b0;
    endtask

    // Counts DEPTH clear edges with Ready required low; optionally tries a write near the end.
    task automatic waitClear(input string tag, input logic [15:0] ignA, input logic [15:0] ignD);
        int early = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 10) begin
                Addr = ignA; WrData = ignD; WR = 1'b1;
            end
            step();
            WR = 1'b0;
            if (Ready !== 1'b0) early++;
        end
        checkVal({tag, "_ready_low"}, 16'(early), 16'd0);
        step();
        checkVal({tag, "_ready_high"}, {15'd0, Ready}, 16'd1);
    endtask

    initial begin
        Reset = 1'b0; Addr = 16'h0000; RD = 1'b0; WR = 1'b0; WrData = 16'h0000;
        #23;
        checkVal("rst_rddata", RdData, 16'h0000);
        checkVal("rst_rdvalid", {15'd0, RdValid}, 16'd0);
        checkVal("rst_ready", {15'd0, Ready}, 16'd0);
`ifdef CVP_MEMRESP_ERR_EN
        checkVal("rst_err", {15'd0, Err}, 16'd0);
`endif
        step();
        Reset = 1'b1;
        // Interrupt the clear part-way; it must restart from address 0.
        for (int i = 0; i < 100; i++) step();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        waitClear("init", 16'h0000, 16'h0000);

        // Cleared word read
        Addr = 16'h0005; RD = 1'b1;
        step();
        RD = 1'b0;
        checkVal("rd5_valid", {15'd0, RdValid}, 16'd1);
        checkVal("rd5_data", RdData, 16'h0000);
        step();
        checkVal("rd5_pulse", {15'd0, RdValid}, 16'd0);

        // Write then immediate read of same address
        doWrite(16'h0010, 16'h7A3C);
        Addr = 16'h0010; RD = 1'b1;
        step();
        RD = 1'b0;
        checkVal("raw_valid", {15'd0, RdValid}, 16'd1);
        checkVal("raw_data", RdData, 16'h7A3C);
        step();
        checkVal("hold_data", RdData, 16'h7A3C);
        checkVal("hold_valid", {15'd0, RdValid}, 16'd0);

        // Back-to-back pipelined reads
        doWrite(16'h0001, 16'h1111);
        doWrite(16'h0002, 16'h2222);
        doWrite(16'h0003, 16'h3333);
        RD = 1'b1;
        Addr = 16'h0001; step();
        checkVal("b2b1_valid", {15'd0, RdValid}, 16'd1);
        checkVal("b2b1_data", RdData, 16'h1111);
        Addr = 16'h0002; step();
        checkVal("b2b2_valid", {15'd0, RdValid}, 16'd1);
        checkVal("b2b2_data", RdData, 16'h2222);
        Addr = 16'h0003; step();
        checkVal("b2b3_valid", {15'd0, RdValid}, 16'd1);
        checkVal("b2b3_data", RdData, 16'h3333);
        RD = 1'b0;
        step();
        checkVal("b2b_end", {15'd0, RdValid}, 16'd0);

        // Illegal RD+WR is dropped
        doWrite(16'h0020, 16'hBEEF);
        Addr = 16'h0020; WrData = 16'h0000; RD = 1'b1; WR = 1'b1;
        step();
        RD = 1'b0; WR = 1'b0;
        checkVal("both_novalid", {15'd0, RdValid}, 16'd0);
`ifdef CVP_MEMRESP_ERR_EN
        checkVal("both_err", {15'd0, Err}, 16'd1);
`endif
        step();
`ifdef CVP_MEMRESP_ERR_EN
        checkVal("both_err_pulse", {15'd0, Err}, 16'd0);
`endif
        Addr = 16'h0020; RD = 1'b1;
        step();
        RD = 1'b0;
        checkVal("both_keep_valid", {15'd0, RdValid}, 16'd1);
        checkVal("both_keep_data", RdData, 16'hBEEF);

        // Out-of-range read and write
        doWrite(16'h0000, 16'h5A5A);
        Addr = 16'h0400; RD = 1'b1;
        step();
        RD = 1'b0;
        checkVal("oor_rd_valid", {15'd0, RdValid}, 16'd1);
`ifdef CVP_MEMRESP_ERR_EN
        checkVal("oor_rd_data", RdData, 16'h0000);
        checkVal("oor_rd_err", {15'd0, Err}, 16'd1);
`else
        checkVal("oor_rd_alias", RdData, 16'h5A5A);
`endif
        doWrite(16'h0400, 16'h1234);
`ifdef CVP_MEMRESP_ERR_EN
        checkVal("oor_wr_err", {15'd0, Err}, 16'd1);
`endif
        Addr = 16'h0000; RD = 1'b1;
        step();
        RD = 1'b0;
`ifdef CVP_MEMRESP_ERR_EN
        checkVal("oor_wr_dropped", RdData, 16'h5A5A);
        checkVal("oor_wr_noerr", {15'd0, Err}, 16'd0);
`else
        checkVal("oor_wr_alias", RdData, 16'h1234);
`endif

        // Reset right after a sampled read flushes it and restarts the clear
        Addr = 16'h0010; RD = 1'b1;
        step();
        RD = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        checkVal("mid_rst_valid", {15'd0, RdValid}, 16'd0);
        checkVal("mid_rst_data", RdData, 16'h0000);
        checkVal("mid_rst_ready", {15'd0, Ready}, 16'd0);
        step();
        step();
        Reset = 1'b1;
        waitClear("reclear", 16'h0030, 16'h9999);
        Addr = 16'h0010; RD = 1'b1;
        step();
        checkVal("reclear_10", RdData, 16'h0000);
        Addr = 16'h0030;
        step();
        RD = 1'b0;
        checkVal("ignored_wr_30", RdData, 16'h0000);
        checkVal("ignored_wr_valid", {15'd0, RdValid}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
